// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE multi-cycle datapath control.
//   seq_state_t       : run/halt sequencer state encoding
//   SIMPLE_NUM_PHASES : phases per instruction (IR, AR/BR, DR/SZCV, MDR/RF, PC)
//   SIMPLE_MEM_PHASE  : 0-based phase index that may stall on memory
package simple_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam int unsigned SIMPLE_NUM_PHASES = 5;
    localparam int unsigned SIMPLE_MEM_PHASE  = 3;

endpackage

// File: rtl/simple_run_sequencer_if.sv
// Control bundle between the SIMPLE datapath/front panel and the run sequencer.
//   master : drives exec, step_mode, halt_req, mem_wait_req, mem_ready;
//            observes phase, running, stalled, halted, retire, inst_count
//   slave  : the sequencer, direction-reversed
interface simple_run_sequencer_if #(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  exec;
    logic                  step_mode;
    logic                  halt_req;
    logic                  mem_wait_req;
    logic                  mem_ready;
    logic [NUM_PHASES-1:0] phase;
    logic                  running;
    logic                  stalled;
    logic                  halted;
    logic                  retire;
    logic [CNT_W-1:0]      inst_count;

    modport master (
        output exec, step_mode, halt_req, mem_wait_req, mem_ready,
        input  phase, running, stalled, halted, retire, inst_count
    );

    modport slave (
        input  exec, step_mode, halt_req, mem_wait_req, mem_ready,
        output phase, running, stalled, halted, retire, inst_count
    );
endinterface

// File: rtl/simple_sync_edge.sv
// Synchronizes an asynchronous level and emits a registered one-cycle pulse on its
// rising edge. Press-to-pulse latency is SYNC_STAGES+1 cycles; a held level pulses once.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   i_async : raw asynchronous input level
//   o_pulse : one-cycle pulse on synchronized rising edge
module simple_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev  <= w_level;
            r_pulse <= w_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/simple_run_sequencer.sv
// Run/halt controller and one-hot phase generator for the SIMPLE datapath.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of simple_run_sequencer_if
//              inputs  exec (async button), step_mode, halt_req, mem_wait_req, mem_ready
//              outputs phase (one-hot/zero), running, stalled, halted, retire, inst_count
// All outputs come straight from flops.
module simple_run_sequencer
    import simple_pkg::*;
#(
    parameter int unsigned NUM_PHASES  = SIMPLE_NUM_PHASES,
    parameter int unsigned MEM_PHASE   = SIMPLE_MEM_PHASE,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic                    clk,
    input logic                    rst,
    simple_run_sequencer_if.slave  bus
);
    localparam logic [NUM_PHASES-1:0] PHASE_FIRST = NUM_PHASES'(1);

    seq_state_t            r_state,   w_state_d;
    logic [NUM_PHASES-1:0] r_phase,   w_phase_d;
    logic                  r_stop,    w_stop_d;
    logic                  r_retire,  w_retire_d;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_d;
    logic                  r_running, r_stalled, r_halted;
    logic                  w_exec_pulse;
    logic                  w_last, w_mem_stall;

    simple_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.exec),
        .o_pulse (w_exec_pulse)
    );

    assign w_last      = r_phase[NUM_PHASES-1];
    assign w_mem_stall = r_phase[MEM_PHASE] & bus.mem_wait_req & ~bus.mem_ready;

    // State register; status flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_stop    <= 1'b0;
            r_retire  <= 1'b0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_stalled <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_phase   <= w_phase_d;
            r_stop    <= w_stop_d;
            r_retire  <= w_retire_d;
            r_cnt     <= w_cnt_d;
            r_running <= (w_state_d == RUN) || (w_state_d == STALL);
            r_stalled <= (w_state_d == STALL);
            r_halted  <= (w_state_d == HALT);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d  = r_state;
        w_phase_d  = r_phase;
        w_stop_d   = r_stop;
        w_retire_d = 1'b0;
        w_cnt_d    = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_exec_pulse) begin
                    w_state_d = RUN;
                    w_phase_d = PHASE_FIRST;
                end
            end
            RUN: begin
                if (w_exec_pulse) w_stop_d = 1'b1;
                if (w_mem_stall) begin
                    w_state_d = STALL;
                end else if (w_last) begin
                    w_retire_d = 1'b1;
                    w_cnt_d    = r_cnt + CNT_W'(1);
                    if (bus.halt_req) begin
                        w_state_d = HALT;
                        w_phase_d = '0;
                        w_stop_d  = 1'b0;
                    end else if (r_stop || w_exec_pulse || bus.step_mode) begin
                        w_state_d = IDLE;
                        w_phase_d = '0;
                        w_stop_d  = 1'b0;
                    end else begin
                        w_phase_d = PHASE_FIRST;
                    end
                end else begin
                    w_phase_d = {r_phase[NUM_PHASES-2:0], 1'b0};
                end
            end
            STALL: begin
                if (w_exec_pulse) w_stop_d = 1'b1;
                if (bus.mem_ready) begin
                    w_state_d = RUN;
                    w_phase_d = {r_phase[NUM_PHASES-2:0], 1'b0};
                end
            end
            HALT: begin
                if (w_exec_pulse) begin
                    w_state_d = RUN;
                    w_phase_d = PHASE_FIRST;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_phase_d = '0;
                w_stop_d  = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.phase      = r_phase;
        bus.running    = r_running;
        bus.stalled    = r_stalled;
        bus.halted     = r_halted;
        bus.retire     = r_retire;
        bus.inst_count = r_cnt;
    end
endmodule

// File: tb/tb_simple_run_sequencer.sv
module tb_simple_run_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    simple_run_sequencer_if #(.NUM_PHASES(5), .CNT_W(16)) bus ();
    simple_run_sequencer_if #(.NUM_PHASES(5), .CNT_W(4))  bus_w ();

    simple_run_sequencer #(
        .NUM_PHASES  (5),
        .MEM_PHASE   (3),
        .SYNC_STAGES (2),
        .CNT_W       (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow-counter copy used to reach the wrap point in a short run.
    simple_run_sequencer #(
        .NUM_PHASES  (5),
        .MEM_PHASE   (3),
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    assign bus_w.exec         = bus.exec;
    assign bus_w.step_mode    = bus.step_mode;
    assign bus_w.halt_req     = bus.halt_req;
    assign bus_w.mem_wait_req = bus.mem_wait_req;
    assign bus_w.mem_ready    = bus.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [4:0] ph, input logic run,
                             input logic stl, input logic hlt, input logic ret,
                             input logic [15:0] cnt);
        chk({tag, ".phase"},   32'(bus.phase),      32'(ph));
        chk({tag, ".running"}, 32'(bus.running),    32'(run));
        chk({tag, ".stalled"}, 32'(bus.stalled),    32'(stl));
        chk({tag, ".halted"},  32'(bus.halted),     32'(hlt));
        chk({tag, ".retire"},  32'(bus.retire),     32'(ret));
        chk({tag, ".count"},   32'(bus.inst_count), 32'(cnt));
    endtask

    // Rising edge on exec; pulse is registered after the third tick.
    task automatic press();
        bus.exec = 1'b1;
        repeat (3) tick();
        bus.exec = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst              = 1'b1;
        bus.exec         = 1'b0;
        bus.step_mode    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.mem_wait_req = 1'b0;
        bus.mem_ready    = 1'b0;

        // Reset takes effect before any clock edge
        #3;
        expect_st("reset", 5'b00000, 0, 0, 0, 0, 16'd0);
        chk("reset.w_count", 32'(bus_w.inst_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        expect_st("idle", 5'b00000, 0, 0, 0, 0, 16'd0);

        // 1: held button gives a single pulse; phase 00001 at press+4
        bus.exec = 1'b1;
        repeat (3) tick();
        chk("t1.pre_phase", 32'(bus.phase), 32'd0);
        tick();
        expect_st("t1.p0", 5'b00001, 1, 0, 0, 0, 16'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("t1.rotate", 32'(bus.phase), 32'(1) << i);
        end
        chk("t1.no_early_retire", 32'(bus.retire), 32'd0);
        tick();
        expect_st("t1.retire1", 5'b00001, 1, 0, 0, 1, 16'd1);
        tick();
        expect_st("t1.after", 5'b00010, 1, 0, 0, 0, 16'd1);
        repeat (3) tick();
        tick();
        expect_st("t1.loop", 5'b00001, 1, 0, 0, 1, 16'd2);
        bus.exec = 1'b0;

        // 2: memory stall in phase 3; wait request outside phase 3 is ignored
        bus.mem_wait_req = 1'b1;
        bus.mem_ready    = 1'b0;
        tick();
        tick();
        chk("t2.ignored", 32'(bus.stalled), 32'd0);
        tick();
        expect_st("t2.memphase", 5'b01000, 1, 0, 0, 0, 16'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_st("t2.stall", 5'b01000, 1, 1, 0, 0, 16'd2);
        end
        bus.mem_ready = 1'b1;
        tick();
        expect_st("t2.resume", 5'b10000, 1, 0, 0, 0, 16'd2);
        bus.mem_wait_req = 1'b0;
        bus.mem_ready    = 1'b0;
        tick();
        expect_st("t2.retire", 5'b00001, 1, 0, 0, 1, 16'd3);
        // ready in the first cycle: no stall
        tick();
        tick();
        bus.mem_wait_req = 1'b1;
        bus.mem_ready    = 1'b1;
        tick();
        expect_st("t2b.memphase", 5'b01000, 1, 0, 0, 0, 16'd3);
        tick();
        expect_st("t2b.advance", 5'b10000, 1, 0, 0, 0, 16'd3);
        bus.mem_wait_req = 1'b0;
        bus.mem_ready    = 1'b0;
        tick();
        expect_st("t2b.retire", 5'b00001, 1, 0, 0, 1, 16'd4);

        // 3: single-step
        bus.step_mode = 1'b1;
        repeat (4) tick();
        chk("t3.last", 32'(bus.phase), 32'b10000);
        tick();
        expect_st("t3.stop", 5'b00000, 0, 0, 0, 1, 16'd5);
        for (int k = 0; k < 2; k++) begin
            press();
            chk("t3.idle_wait", 32'(bus.phase), 32'd0);
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("t3.phase", 32'(bus.phase), 32'(1) << i);
                chk("t3.running", 32'(bus.running), 32'd1);
            end
            tick();
            expect_st("t3.step_retire", 5'b00000, 0, 0, 0, 1, 16'(6 + k));
            tick();
            expect_st("t3.step_idle", 5'b00000, 0, 0, 0, 0, 16'(6 + k));
        end

        // 4: halt wins over stop_pending; halt_req ignored outside last phase
        bus.step_mode = 1'b0;
        press();
        tick();
        expect_st("t4.run", 5'b00001, 1, 0, 0, 0, 16'd7);
        bus.halt_req = 1'b1;
        press();
        expect_st("t4.halt_ignored", 5'b01000, 1, 0, 0, 0, 16'd7);
        tick();
        expect_st("t4.last", 5'b10000, 1, 0, 0, 0, 16'd7);
        tick();
        expect_st("t4.halt", 5'b00000, 0, 0, 1, 1, 16'd8);
        bus.step_mode = 1'b1;
        repeat (2) tick();
        expect_st("t4.halt_hold", 5'b00000, 0, 0, 1, 0, 16'd8);
        bus.step_mode = 1'b0;
        bus.halt_req  = 1'b0;
        press();
        chk("t4.still_halted", 32'(bus.halted), 32'd1);
        tick();
        expect_st("t4.resume", 5'b00001, 1, 0, 0, 0, 16'd8);
        repeat (4) tick();
        tick();
        expect_st("t4.no_stale_stop", 5'b00001, 1, 0, 0, 1, 16'd9);

        // 6: asynchronous reset mid-instruction
        tick();
        tick();
        chk("t6.phase2", 32'(bus.phase), 32'b00100);
        #2;
        rst = 1'b1;
        #1;
        expect_st("t6.async_rst", 5'b00000, 0, 0, 0, 0, 16'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        expect_st("t6.idle", 5'b00000, 0, 0, 0, 0, 16'd0);

        // 5: counter wrap on the 4-bit copy, no wrap on the 16-bit one
        press();
        tick();
        chk("t5.start", 32'(bus.phase), 32'b00001);
        repeat (75) tick();
        chk("t5.count15", 32'(bus.inst_count), 32'd15);
        chk("t5.w_count15", 32'(bus_w.inst_count), 32'd15);
        repeat (5) tick();
        chk("t5.w_wrap", 32'(bus_w.inst_count), 32'd0);
        chk("t5.w_retire", 32'(bus_w.retire), 32'd1);
        chk("t5.count16", 32'(bus.inst_count), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
